// File: rtl/tomasulo_pkg.sv
// +----------------------------------------------------------------------+
// | tomasulo_pkg: shared types for the load/store buffer                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package tomasulo_pkg;

  localparam int MAU_TAG_W = 4;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    BCAST   = 3'd3,
    ST_RET  = 3'd4
  } mau_state_t;

  typedef struct packed {
    logic                 is_store;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [MAU_TAG_W-1:0] tag;
  } lsq_entry_t;

endpackage

`default_nettype wire

// File: rtl/lsq_fifo.sv
// +----------------------------------------------------------------------+
// | lsq_fifo: in-order queue of pending memory ops with flush            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsq_fifo
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enq,
  input  lsq_entry_t                   enq_entry,
  input  logic                         deq,
  input  logic                         flush,
  output lsq_entry_t                   head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  lsq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             do_enq;
  logic             do_deq;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  // Flush wins over both sides so a same-cycle enqueue is dropped.
  assign do_enq = enq && !full && !flush;
  assign do_deq = deq && !empty && !flush;
  assign head   = mem[rd_ptr];
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------+
// | mem_access_unit: in-order load/store issue to a multi-cycle RAM      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import tomasulo_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = MAU_TAG_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic             enq_is_store,
  input  logic [31:0]      enq_addr,
  input  logic [31:0]      enq_data,
  input  logic [TAG_W-1:0] enq_tag,
  input  logic             flush,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  output logic             ram_nrd,
  output logic             ram_nwr,
  input  logic [31:0]      ram_rdata,
  input  logic             ram_rd_ok,
  input  logic             ram_wr_ok,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  output logic             cdb_err,
  output logic             st_done,
  output logic [TAG_W-1:0] st_tag,
  output logic             timeout_err
);

  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYC);

  lsq_entry_t       enq_entry;
  lsq_entry_t       head;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  logic             q_deq;

  mau_state_t       state_q, state_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             nrd_q, nrd_d, nwr_q, nwr_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d, st_tag_q, st_tag_d;
  logic [31:0]      cdb_data_q, cdb_data_d;
  logic             cdb_err_q, cdb_err_d;
  logic             tmo_err_q, tmo_err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign enq_entry = '{is_store: enq_is_store, addr: enq_addr, data: enq_data, tag: enq_tag};
  assign enq_ready = (q_count != CNT_W'(DEPTH));

  lsq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq       (enq_valid && enq_ready),
    .enq_entry (enq_entry),
    .deq       (q_deq),
    .flush     (flush),
    .head      (head),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      nrd_q      <= 1'b1;
      nwr_q      <= 1'b1;
      op_tag_q   <= '0;
      cdb_tag_q  <= '0;
      cdb_data_q <= '0;
      cdb_err_q  <= 1'b0;
      st_tag_q   <= '0;
      tmo_err_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nrd_q      <= nrd_d;
      nwr_q      <= nwr_d;
      op_tag_q   <= op_tag_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_err_q  <= cdb_err_d;
      st_tag_q   <= st_tag_d;
      tmo_err_q  <= tmo_err_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    nrd_d      = nrd_q;
    nwr_d      = nwr_q;
    op_tag_d   = op_tag_q;
    cdb_tag_d  = cdb_tag_q;
    cdb_data_d = cdb_data_q;
    cdb_err_d  = cdb_err_q;
    st_tag_d   = st_tag_q;
    tmo_err_d  = tmo_err_q;
    tmo_d      = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    q_deq      = 1'b0;

    case (state_q)
      IDLE: begin
        // Wait for the previous RAM status to drop before the next issue.
        if (!q_empty && !ram_rd_ok && !ram_wr_ok && !flush) begin
          q_deq    = 1'b1;
          op_tag_d = head.tag;
          tmo_d    = '0;
          if (head.addr[1:0] != 2'b00) begin
            if (head.is_store == OP_STORE) begin
              st_tag_d = head.tag;
              state_d  = ST_RET;
            end else begin
              cdb_tag_d  = head.tag;
              cdb_data_d = '0;
              cdb_err_d  = 1'b1;
              state_d    = BCAST;
            end
          end else begin
            addr_d = head.addr;
            if (head.is_store == OP_STORE) begin
              wdata_d = head.data;
              nwr_d   = 1'b0;
              state_d = WR_WAIT;
            end else begin
              nrd_d   = 1'b0;
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (ram_rd_ok) begin
          nrd_d      = 1'b1;
          cdb_tag_d  = op_tag_q;
          cdb_data_d = ram_rdata;
          cdb_err_d  = 1'b0;
          state_d    = BCAST;
        end else if (tmo_q == TMO_LAST) begin
          nrd_d      = 1'b1;
          cdb_tag_d  = op_tag_q;
          cdb_data_d = '0;
          cdb_err_d  = 1'b1;
          tmo_err_d  = 1'b1;
          state_d    = BCAST;
        end
      end
      WR_WAIT: begin
        if (ram_wr_ok || tmo_q == TMO_LAST) begin
          nwr_d    = 1'b1;
          st_tag_d = op_tag_q;
          state_d  = ST_RET;
          if (!ram_wr_ok) tmo_err_d = 1'b1;
        end
      end
      BCAST: begin
        if (cdb_ready) state_d = IDLE;
      end
      ST_RET: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        nrd_d   = 1'b1;
        nwr_d   = 1'b1;
      end
    endcase
  end

  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign ram_nrd     = nrd_q;
  assign ram_nwr     = nwr_q;
  assign cdb_valid   = (state_q == BCAST);
  assign cdb_tag     = cdb_tag_q;
  assign cdb_data    = cdb_data_q;
  assign cdb_err     = cdb_err_q;
  assign st_done     = (state_q == ST_RET);
  assign st_tag      = st_tag_q;
  assign timeout_err = tmo_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------+
// | tb_mem_access_unit: directed bench with a latency-programmable RAM   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enq_valid, enq_ready, enq_is_store;
  logic [31:0] enq_addr, enq_data;
  logic [3:0]  enq_tag;
  logic        flush;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_nrd, ram_nwr, ram_rd_ok, ram_wr_ok;
  logic        cdb_valid, cdb_ready, cdb_err;
  logic [3:0]  cdb_tag, st_tag;
  logic [31:0] cdb_data;
  logic        st_done, timeout_err;

  int errors = 0;
  int checks = 0;

  // RAM model: status rises once the strobe has been low for lat cycles.
  int          lat = 1;
  bit          hang = 1'b0;
  int          rcnt = 0;
  int          wcnt = 0;
  logic [31:0] mem [0:63];
  bit          wrote [0:63];
  int          stab_viol = 0;
  logic        prev_low = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(4), .TAG_W(4), .TIMEOUT_CYC(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_is_store (enq_is_store),
    .enq_addr     (enq_addr),
    .enq_data     (enq_data),
    .enq_tag      (enq_tag),
    .flush        (flush),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_nrd      (ram_nrd),
    .ram_nwr      (ram_nwr),
    .ram_rdata    (ram_rdata),
    .ram_rd_ok    (ram_rd_ok),
    .ram_wr_ok    (ram_wr_ok),
    .cdb_valid    (cdb_valid),
    .cdb_ready    (cdb_ready),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_err      (cdb_err),
    .st_done      (st_done),
    .st_tag       (st_tag),
    .timeout_err  (timeout_err)
  );

  assign ram_rd_ok = !ram_nrd && !hang && (rcnt >= lat - 1);
  assign ram_wr_ok = !ram_nwr && !hang && (wcnt >= lat - 1);
  assign ram_rdata = !ram_rd_ok ? 32'h0 :
                     wrote[ram_addr[7:2]] ? mem[ram_addr[7:2]] :
                     (ram_addr == 32'h10) ? 32'hDEADBEEF : {16'hC0DE, ram_addr[15:0]};

  always @(posedge clk) begin
    rcnt <= ram_nrd ? 0 : rcnt + 1;
    wcnt <= ram_nwr ? 0 : wcnt + 1;
    if (ram_wr_ok) begin
      mem[ram_addr[7:2]]   <= ram_wdata;
      wrote[ram_addr[7:2]] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if ((!ram_nrd || !ram_nwr) && prev_low &&
        (ram_addr !== prev_addr || ram_wdata !== prev_wdata))
      stab_viol = stab_viol + 1;
    prev_low   = !ram_nrd || !ram_nwr;
    prev_addr  = ram_addr;
    prev_wdata = ram_wdata;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic enq(input bit st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
    enq_valid = 1'b1; enq_is_store = st; enq_addr = a; enq_data = d; enq_tag = t;
    @(negedge clk);
    enq_valid = 1'b0;
  endtask

  // Wait for cdb_valid, counting cycles the read / write strobes were low.
  task automatic wait_cdb(output int rd_low, output int wr_low, output bit seen);
    rd_low = 0; wr_low = 0; seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!ram_nrd) rd_low++;
      if (!ram_nwr) wr_low++;
      if (cdb_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  int          rd_low, wr_low, n;
  bit          seen, st_seen, st_first;
  logic [3:0]  st_tag_seen, first_tag;
  logic [3:0]  got_tag [6];
  logic [31:0] got_data [6];
  bit          pend_clear;

  initial begin
    rst_n = 1'b0; enq_valid = 1'b0; enq_is_store = 1'b0; enq_addr = '0;
    enq_data = '0; enq_tag = '0; flush = 1'b0; cdb_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_nrd", ram_nrd, 1);
    check("rst_nwr", ram_nwr, 1);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_cdb", {cdb_valid, cdb_err, cdb_tag}, 0);
    check("rst_cdb_data", cdb_data, 0);
    check("rst_st", {st_done, st_tag}, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_ready", enq_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned load, RAM latency 10.
    lat = 10;
    enq(1'b0, 32'h10, 32'h0, 4'd3);
    wait_cdb(rd_low, wr_low, seen);
    check("ld_seen", seen, 1);
    check("ld_nrd_low", rd_low, 10);
    check("ld_tag", cdb_tag, 3);
    check("ld_data", cdb_data, 32'hDEADBEEF);
    check("ld_err", cdb_err, 0);
    check("ld_nrd_hi", ram_nrd, 1);
    @(negedge clk);
    check("ld_valid_drop", cdb_valid, 0);

    // Store then load of the same word.
    lat = 3;
    enq(1'b1, 32'h20, 32'h12345678, 4'd5);
    enq(1'b0, 32'h20, 32'h0, 4'd6);
    st_seen = 1'b0; st_first = 1'b0; st_tag_seen = '0; seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (st_done && !st_seen) begin st_seen = 1'b1; st_tag_seen = st_tag; end
      if (cdb_valid) begin seen = 1'b1; st_first = st_seen; break; end
      @(negedge clk);
    end
    check("st_before_ld", st_first, 1);
    check("st_tag", st_tag_seen, 5);
    check("stld_tag", cdb_tag, 6);
    check("stld_data", cdb_data, 32'h12345678);
    @(negedge clk);

    // Queue fills behind a stalled load; extra op is held off.
    hang = 1'b1; lat = 2;
    enq(1'b0, 32'h40, 32'h0, 4'd1);
    enq(1'b0, 32'h44, 32'h0, 4'd2);
    enq(1'b0, 32'h48, 32'h0, 4'd3);
    enq(1'b0, 32'h4C, 32'h0, 4'd4);
    enq(1'b0, 32'h50, 32'h0, 4'd5);
    check("full_ready", enq_ready, 0);
    enq_valid = 1'b1; enq_is_store = 1'b0; enq_addr = 32'h54; enq_tag = 4'd6;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (enq_ready || cdb_valid) n++;
    end
    check("full_held", n, 0);
    hang = 1'b0;
    n = 0; pend_clear = 1'b0;
    for (int c = 0; c < 400 && n < 6; c++) begin
      @(negedge clk);
      if (pend_clear) begin enq_valid = 1'b0; pend_clear = 1'b0; end
      else if (enq_valid && enq_ready) pend_clear = 1'b1;
      if (cdb_valid) begin got_tag[n] = cdb_tag; got_data[n] = cdb_data; n++; end
    end
    enq_valid = 1'b0;
    check("fifo_count", n, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fifo_tag%0d", i), got_tag[i], i + 1);
      check($sformatf("fifo_data%0d", i), got_data[i], 32'hC0DE0040 + 4 * i);
    end
    @(negedge clk);

    // Misaligned load and store never touch the RAM.
    enq(1'b0, 32'h13, 32'h0, 4'd2);
    wait_cdb(rd_low, wr_low, seen);
    check("mis_ld_seen", seen, 1);
    check("mis_ld_strobe", rd_low, 0);
    check("mis_ld_cdb", {cdb_err, cdb_tag}, {1'b1, 4'd2});
    check("mis_ld_data", cdb_data, 0);
    @(negedge clk);
    enq(1'b1, 32'h22, 32'h5555AAAA, 4'd4);
    st_seen = 1'b0; wr_low = 0;
    for (int c = 0; c < 20 && !st_seen; c++) begin
      if (!ram_nwr) wr_low++;
      if (st_done) begin st_seen = 1'b1; st_tag_seen = st_tag; end
      else @(negedge clk);
    end
    check("mis_st_done", {st_seen, st_tag_seen}, {1'b1, 4'd4});
    check("mis_st_strobe", wr_low, 0);
    check("pre_tmo", timeout_err, 0);
    @(negedge clk);

    // RAM never answers: abort after the timeout.
    hang = 1'b1;
    enq(1'b0, 32'h10, 32'h0, 4'd7);
    wait_cdb(rd_low, wr_low, seen);
    check("tmo_seen", seen, 1);
    check("tmo_nrd_low", rd_low, 64);
    check("tmo_nrd_hi", ram_nrd, 1);
    check("tmo_cdb", {cdb_err, cdb_tag}, {1'b1, 4'd7});
    check("tmo_data", cdb_data, 0);
    check("tmo_sticky", timeout_err, 1);
    hang = 1'b0;
    @(negedge clk);

    // CDB back-pressure: outputs hold while cdb_ready is low.
    cdb_ready = 1'b0; lat = 2;
    enq(1'b0, 32'h10, 32'h0, 4'd9);
    wait_cdb(rd_low, wr_low, seen);
    check("bp_seen", seen, 1);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (cdb_valid !== 1'b1 || cdb_tag !== 4'd9 || cdb_data !== 32'hDEADBEEF || cdb_err !== 1'b0) n++;
    end
    check("bp_stable", n, 0);
    cdb_ready = 1'b1;
    @(negedge clk);
    check("bp_release", cdb_valid, 0);

    // Flush with three queued behind an in-flight load.
    hang = 1'b1;
    enq(1'b0, 32'h10, 32'h0, 4'd10);
    enq(1'b0, 32'h44, 32'h0, 4'd11);
    enq(1'b0, 32'h48, 32'h0, 4'd12);
    enq(1'b0, 32'h4C, 32'h0, 4'd13);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; hang = 1'b0;
    n = 0; first_tag = '0;
    repeat (40) begin
      @(negedge clk);
      if (cdb_valid) begin if (n == 0) first_tag = cdb_tag; n++; end
    end
    check("flush_count", n, 1);
    check("flush_tag", first_tag, 10);
    check("flush_ready", enq_ready, 1);
    enq(1'b0, 32'h44, 32'h0, 4'd14);
    wait_cdb(rd_low, wr_low, seen);
    check("post_flush", {seen, cdb_tag}, {1'b1, 4'd14});
    check("post_flush_data", cdb_data, 32'hC0DE0044);
    check("tmo_still", timeout_err, 1);
    check("addr_stable", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
